ranged_bit_packer: RTL
======================

# ranged_bit_packer

Serial-to-parallel packer that assembles a stream of single bits into a word declared with a non-zero-based index range, either descending (`[LSB_IDX+WIDTH-1:LSB_IDX]`) or ascending (`[LSB_IDX:LSB_IDX+WIDTH-1]`). It is the writer-side counterpart of bit-select extraction from offset ranges: each incoming bit is written to element `LSB_IDX+n` of the declared vector. It sits between a bit-serial source and a word-wide consumer, with valid/ready handshakes on both sides, and doubles as a regression vehicle for offset-range bit-select writes.

## Interface

- `WIDTH`, 8: number of bits per word, ≥ 1.
- `LSB_IDX`, 1: lowest declared index of the word range.
- `ASCENDING`, 0: 0 = word declared `[LSB_IDX+WIDTH-1:LSB_IDX]`; 1 = word declared `[LSB_IDX:LSB_IDX+WIDTH-1]`.
- `clk_i`  in  1  clock, rising edge.
- `rst_ni`  in  1  reset, synchronous, active-low.
- `bit_valid_i`  in  1  serial bit present.
- `bit_ready_o`  out  1  packer accepts bit this cycle.
- `bit_i`  in  1  serial data bit.
- `word_valid_o`  out  1  assembled word available.
- `word_ready_i`  in  1  consumer takes word.
- `word_o`  out  WIDTH  assembled word, in declared range orientation.
- `len_o`  out  $clog2(WIDTH+1)  number of valid bits in `word_o`. Present only with `RANGED_PACKER_FLUSH_EN`.
- `flush_i`  in  1  terminate the current word early. Present only with `RANGED_PACKER_FLUSH_EN`.

Clocking: one clock; reset is synchronous and active-low (`clk_i`, `rst_ni`).

## Operation

- States: FILL, HOLD.
- **FILL**
  - `bit_ready_o` = 1.
  - On `bit_valid_i`, write `word[LSB_IDX+cnt] <= bit_i`, then `cnt++`.
  - Accepting the bit with `cnt == WIDTH-1` moves to HOLD.
- **HOLD**
  - `word_valid_o` = 1 and `bit_ready_o` = 0.
  - On `word_ready_i`, go to FILL with `cnt` = 0 and the word register cleared to 0.
- **Index mapping:** logical index `LSB_IDX+n` maps to physical bit `n` when `ASCENDING=0`, and to physical bit `WIDTH-1-n` when `ASCENDING=1`.
  - The first bit received is always the lowest declared index.
  - No out-of-range index is ever generated; `cnt` saturates at `WIDTH-1` in FILL.
- **Counter arithmetic:** `cnt` is `$clog2(WIDTH+1)` bits, unsigned. Its comparison against `WIDTH-1` is done at counter width.
- **Reset:** reset has priority over all other events.
  - Reset values: state FILL, `cnt` 0, `word_o` 0, `word_valid_o` 0, `bit_ready_o` 0 while `rst_ni` is low, `len_o` 0.
  - A reset mid-fill discards the partial word.

## Timing

- `bit_ready_o` and `word_valid_o` are registered-state decodes; neither depends combinationally on any input.
- Latency: the last bit is accepted in cycle N; `word_valid_o` is high in cycle N+1.
- Throughput: one HOLD cycle per word. Bits cannot be accepted in a cycle where `word_valid_o && word_ready_i`, which gives one bubble per word.
- `word_o` is held stable while `word_valid_o && !word_ready_i`.
- `bit_valid_i` while `bit_ready_o` = 0 is ignored. The source must hold the bit until it is accepted.

## Configuration

- `RANGED_PACKER_FLUSH_EN` defined:
  - Adds `flush_i` and `len_o`.
  - `flush_i` in FILL with `cnt` > 0 moves to HOLD next cycle. Unfilled positions stay 0 and `len_o` = `cnt`, plus 1 if a bit is accepted in the same cycle.
  - A full word gives `len_o` = `WIDTH`.
  - `flush_i` with `cnt` = 0 and no bit accepted is ignored.
  - `flush_i` in HOLD is ignored.
- `RANGED_PACKER_FLUSH_EN` undefined: neither port exists and words are always complete.

## Structure

- Package `ranged_pkg`:
  - State enum `packer_state_e` {FILL, HOLD}.
  - Function `ranged_phys_idx(width, lsb_idx, ascending, logical)` returning the physical bit position.
- Sub-module `ranged_bit_index`: combinational logical→physical decode for the write enable. It is reused by the future matching unpacker.

## Test plan

- Default parameters (`ASCENDING=0`, `LSB_IDX=1`): stream 1,0,0,0,0,0,0,0 → `word_o` = 8'h01, `word_valid_o` high one cycle after the 8th accept.
- `ASCENDING=1`, `LSB_IDX=2`: same stream → `word_o` = 8'h80. Stream 0,0,0,0,0,0,0,1 → 8'h01.
- Backpressure: `word_ready_i` low for 3 cycles after a word completes → `word_o` stable, `bit_ready_o` = 0, `bit_valid_i` ignored. Word is taken on cycle 4 and FILL resumes next cycle.
- Reset mid-fill: drop `rst_ni` after 3 accepted bits → all outputs 0. The next 8 bits (all 1) give `word_o` = 8'hFF.
- With `RANGED_PACKER_FLUSH_EN`, `ASCENDING=0`: bits 1,1,1 then `flush_i` → `word_o` = 8'h07, `len_o` = 3.
- With `RANGED_PACKER_FLUSH_EN`, `ASCENDING=1`: bits 1,1,1 then `flush_i` → `word_o` = 8'hE0, `len_o` = 3.
- `WIDTH=1`, `LSB_IDX=5`: each accepted bit completes a word → alternating FILL/HOLD and `word_o` equals `bit_i`.

Source files
------------

// File: rtl/ranged_pkg.sv
// Shared types and index helpers for the ranged bit packer.
// Maps declared (offset) word indices onto physical vector bits.
package ranged_pkg;

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } packer_state_e;

    // Physical bit position of declared index `logical`
    function automatic int ranged_phys_idx(
        input int width,
        input int lsb_idx,
        input bit ascending,
        input int logical
    );
        int off;
        off = logical - lsb_idx;
        return ascending ? (width - 1 - off) : off;
    endfunction

endpackage

// File: rtl/ranged_bit_index.sv
// One-hot write enable for declared index LSB_IDX+cnt.
// Shared with the matching unpacker.
module ranged_bit_index
    import ranged_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int LSB_IDX   = 1,
    parameter int ASCENDING = 0,
    localparam int CW       = $clog2(WIDTH + 1)
) (
    input  logic             en,
    input  logic [CW-1:0]    cnt,
    output logic [WIDTH-1:0] we
);

    // decode the current logical slot into a physical one-hot strobe
    always_comb begin
        we = '0;
        for (int p = 0; p < WIDTH; p++) begin
            if (en && ranged_phys_idx(WIDTH, LSB_IDX, ASCENDING != 0,
                                      LSB_IDX + int'(cnt)) == p) begin
                we[p] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ranged_bit_packer.sv
// Bit-serial to word packer over an offset declared index range.
// Optional early-termination flush: RANGED_PACKER_FLUSH_EN.
module ranged_bit_packer
    import ranged_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int LSB_IDX   = 1,
    parameter int ASCENDING = 0
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         bit_valid_i,
    output logic                         bit_ready_o,
    input  logic                         bit_i,
    output logic                         word_valid_o,
    input  logic                         word_ready_i,
`ifdef RANGED_PACKER_FLUSH_EN
    input  logic                         flush_i,
    output logic [$clog2(WIDTH+1)-1:0]   len_o,
`endif
    output logic [WIDTH-1:0]             word_o
);

    localparam int            CW   = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    packer_state_e    state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] word_q, word_d;
    logic [WIDTH-1:0] we;
    logic             run_q;
    logic             accept;
    logic             flush_go;

    // run_q keeps ready low through reset without a path from rst_ni
    assign accept = run_q && (state_q == FILL) && bit_valid_i;

`ifdef RANGED_PACKER_FLUSH_EN
    assign flush_go = run_q && flush_i && ((cnt_q != '0) || accept);
    assign len_o    = cnt_q;
`else
    assign flush_go = 1'b0;
`endif

    ranged_bit_index #(
        .WIDTH    (WIDTH),
        .LSB_IDX  (LSB_IDX),
        .ASCENDING(ASCENDING)
    ) u_idx (
        .en (accept),
        .cnt(cnt_q),
        .we (we)
    );

    // next-state, counter and word update
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        word_d  = word_q;
        unique case (state_q)
            FILL: begin
                if (accept) begin
                    word_d = (word_q & ~we) | (we & {WIDTH{bit_i}});
                    cnt_d  = cnt_q + CW'(1);
                end
                if ((accept && cnt_q == LAST) || flush_go) begin
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (word_ready_i) begin
                    state_d = FILL;
                    cnt_d   = '0;
                    word_d  = '0;
                end
            end
            default: ;
        endcase
    end

    // state registers with synchronous active-low reset
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= FILL;
            cnt_q   <= '0;
            word_q  <= '0;
            run_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            word_q  <= word_d;
            run_q   <= 1'b1;
        end
    end

    assign bit_ready_o  = run_q && (state_q == FILL);
    assign word_valid_o = (state_q == HOLD);
    assign word_o       = word_q;

endmodule
